cfg_frame_receiver: RTL and testbench

- Receive-side counterpart of the 1 MHz configuration sender. Sits at the analog-ASIC end of the bridge.
- Deserialises the SEL/MOSI/gated-clock stream into the 16-bit DYNCNF and 88-bit STATCNF registers.
- All three serial inputs are oversampled in the CLK domain; the gated serial clock is never used as a clock.
- Flags framing errors and stalled frames; holds the last good configuration until a new frame commits.

---
 rtl/cfg_bridge_pkg.sv | 18 +
 rtl/cfg_sync_bus.sv | 41 ++++
 rtl/cfg_frame_receiver.sv | 145 ++++++++++++++
 tb/tb_cfg_frame_receiver.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cfg_bridge_pkg.sv
// Shared definitions for the configuration bridge (sender and receiver).
// Holds the receiver state encoding, default register sizes and the default configuration words.
package cfg_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DYN_RX  = 2'd1,
        ST_STAT_RX = 2'd2,
        ST_DONE    = 2'd3
    } rx_state_t;

    localparam int SIZESRDYN_DEF  = 16;
    localparam int SIZESRSTAT_DEF = 88;

    localparam logic [15:0] DYNCNF_DEF  = 16'hABC6;
    localparam logic [87:0] STATCNF_DEF = 88'h123456789ABCDEF1234567;

endpackage

// File: rtl/cfg_sync_bus.sv
// Multi-stage synchroniser for the SCLK/SEL/MOSI bundle plus SCLK rising-edge detect.
// Ports: i_clk, i_rst_n, i_sclk/i_sel/i_mosi (async) -> o_sel, o_mosi, o_rise (CLK domain).
module cfg_sync_bus #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sclk,
    input  logic i_sel,
    input  logic i_mosi,
    output logic o_sel,
    output logic o_mosi,
    output logic o_rise
);

    // All three lines share one chain so they stay mutually aligned.
    logic [2:0] r_stg [SYNC_STAGES];
    logic       r_sclk_d;
    logic [2:0] w_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_stg[i] <= 3'b000;
            end
            r_sclk_d <= 1'b0;
        end else begin
            r_stg[0] <= {i_mosi, i_sel, i_sclk};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stg[i] <= r_stg[i-1];
            end
            r_sclk_d <= r_stg[SYNC_STAGES-1][0];
        end
    end

    assign w_sync = r_stg[SYNC_STAGES-1];
    assign o_sel  = w_sync[1];
    assign o_mosi = w_sync[2];
    assign o_rise = w_sync[0] & ~r_sclk_d;

endmodule

// File: rtl/cfg_frame_receiver.sv
// Oversampling receiver for the SEL/MOSI/gated-SCLK configuration stream.
// Ports: CLK, RST_N, SCLK_IN/SEL_IN/MOSI_IN -> DYNCNF, STATCNF, dyn_valid, stat_valid, cfg_ready, frame_err, busy.
module cfg_frame_receiver
    import cfg_bridge_pkg::*;
#(
    parameter int                  SIZESRDYN      = SIZESRDYN_DEF,
    parameter int                  SIZESRSTAT     = SIZESRSTAT_DEF,
    parameter int                  SYNC_STAGES    = 2,
    parameter int                  TIMEOUT_CYCLES = 1024,
    parameter logic [SIZESRDYN-1:0]  DYNCNF_RST   = '0,
    parameter logic [SIZESRSTAT-1:0] STATCNF_RST  = '0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  SCLK_IN,
    input  logic                  SEL_IN,
    input  logic                  MOSI_IN,
    output logic [SIZESRDYN-1:0]  DYNCNF,
    output logic [SIZESRSTAT-1:0] STATCNF,
    output logic                  dyn_valid,
    output logic                  stat_valid,
    output logic                  cfg_ready,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic w_sel_s, w_mosi_s, w_rise;

    cfg_sync_bus #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk  (CLK),
        .i_rst_n(RST_N),
        .i_sclk (SCLK_IN),
        .i_sel  (SEL_IN),
        .i_mosi (MOSI_IN),
        .o_sel  (w_sel_s),
        .o_mosi (w_mosi_s),
        .o_rise (w_rise)
    );

    rx_state_t r_state, w_nxt;
    logic [6:0]  r_cnt;
    logic [TW-1:0] r_tmo;
    // The final bit goes straight from the line into the commit,
    // so the register keeps one bit less than the static word.
    logic [SIZESRSTAT-2:0] r_shreg;

    logic w_start, w_shift, w_dcommit, w_scommit, w_err;
    logic w_tmo_exp;

    assign w_tmo_exp = (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= ST_IDLE;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt     = r_state;
        w_start   = 1'b0;
        w_shift   = 1'b0;
        w_dcommit = 1'b0;
        w_scommit = 1'b0;
        w_err     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_rise && w_sel_s) begin
                    w_start = 1'b1;
                    w_nxt   = ST_DYN_RX;
                end
            end
            ST_DYN_RX: begin
                if (w_rise && w_sel_s) begin
                    w_shift = 1'b1;
                    if (r_cnt == 7'(SIZESRDYN - 1)) begin
                        w_dcommit = 1'b1;
                        w_nxt     = ST_STAT_RX;
                    end
                end else if (w_rise || w_tmo_exp) begin
                    w_err = 1'b1;
                    w_nxt = ST_IDLE;
                end
            end
            ST_STAT_RX: begin
                if (w_rise && !w_sel_s) begin
                    w_shift = 1'b1;
                    if (r_cnt == 7'(SIZESRSTAT - 1)) begin
                        w_scommit = 1'b1;
                        w_nxt     = ST_DONE;
                    end
                end else if (w_rise || w_tmo_exp) begin
                    w_err = 1'b1;
                    w_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!w_sel_s) w_nxt = ST_IDLE;
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

    assign busy = (r_state == ST_DYN_RX) || (r_state == ST_STAT_RX);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt      <= '0;
            r_tmo      <= '0;
            r_shreg    <= '0;
            DYNCNF     <= DYNCNF_RST;
            STATCNF    <= STATCNF_RST;
            dyn_valid  <= 1'b0;
            stat_valid <= 1'b0;
            cfg_ready  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            dyn_valid  <= w_dcommit;
            stat_valid <= w_scommit;
            frame_err  <= w_err;

            if (w_start || w_shift) begin
                r_shreg <= {r_shreg[SIZESRSTAT-3:0], w_mosi_s};
            end

            // The bit captured on the IDLE exit already counts as bit one.
            if (w_start)               r_cnt <= 7'd1;
            else if (w_nxt != r_state) r_cnt <= '0;
            else if (w_shift)          r_cnt <= r_cnt + 7'd1;

            // Runs only while staying in a receive state between rises.
            if (busy && (w_nxt == r_state) && !w_rise) r_tmo <= r_tmo + 1'b1;
            else                                       r_tmo <= '0;

            if (w_dcommit) DYNCNF  <= {r_shreg[SIZESRDYN-2:0], w_mosi_s};
            if (w_scommit) STATCNF <= {r_shreg, w_mosi_s};

            if (w_start)        cfg_ready <= 1'b0;
            else if (w_scommit) cfg_ready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cfg_frame_receiver.sv
// Randomised self-checking bench for cfg_frame_receiver.
// Drives serial frames at several CLK/SCLK ratios and compares against a frame-level model.
module tb_cfg_frame_receiver;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        SCLK_IN = 1'b0;
    logic        SEL_IN = 1'b0;
    logic        MOSI_IN = 1'b0;
    logic [15:0] DYNCNF;
    logic [87:0] STATCNF;
    logic        dyn_valid, stat_valid, cfg_ready, frame_err, busy;

    cfg_frame_receiver u_dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .SCLK_IN   (SCLK_IN),
        .SEL_IN    (SEL_IN),
        .MOSI_IN   (MOSI_IN),
        .DYNCNF    (DYNCNF),
        .STATCNF   (STATCNF),
        .dyn_valid (dyn_valid),
        .stat_valid(stat_valid),
        .cfg_ready (cfg_ready),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_dv = 0, n_sv = 0, n_err = 0;
    int t_sv = 0, t_err = 0, t_rise = 0;

    // Frame-level reference: what the receiver should hold after each transaction.
    logic [15:0] exp_dyn;
    logic [87:0] exp_stat;
    logic        exp_ready;
    int          exp_dv, exp_sv, exp_err;

    always @(posedge CLK) begin
        cyc++;
        #1;
        if (dyn_valid) n_dv++;
        if (stat_valid) begin n_sv++; t_sv = cyc; end
        if (frame_err) begin n_err++; t_err = cyc; end
    end

    task automatic chk(input string tag, input logic [87:0] got, input logic [87:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic model_reset();
        exp_dyn   = 16'h0;
        exp_stat  = 88'h0;
        exp_ready = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".dyn"},   DYNCNF, exp_dyn);
        chk({tag, ".stat"},  STATCNF, exp_stat);
        chk({tag, ".ready"}, cfg_ready, exp_ready);
        chk({tag, ".n_dv"},  n_dv, exp_dv);
        chk({tag, ".n_sv"},  n_sv, exp_sv);
        chk({tag, ".n_err"}, n_err, exp_err);
        chk({tag, ".busy"},  busy, 1'b0);
    endtask

    task automatic send_bit(input logic sel, input logic d, input int lo, input int hi);
        SEL_IN  = sel;
        MOSI_IN = d;
        SCLK_IN = 1'b0;
        tick(lo);
        SCLK_IN = 1'b1;
        t_rise  = cyc;
        tick(hi);
        SCLK_IN = 1'b0;
    endtask

    task automatic send_dyn(input logic [15:0] d, input int lo, input int hi);
        for (int i = 15; i >= 0; i--) begin
            send_bit(1'b1, d[i], lo, hi);
            if (i == 15) begin
                tick(3);
                chk("start.ready_clr", cfg_ready, 1'b0);
                chk("start.busy", busy, 1'b1);
            end
        end
    endtask

    task automatic send_frame(input string tag, input logic [15:0] d,
                              input logic [87:0] s, input int lo, input int hi);
        send_dyn(d, lo, hi);
        for (int i = 87; i >= 0; i--) send_bit(1'b0, s[i], lo, hi);
        tick(6);
        SEL_IN = 1'b1;
        exp_dyn   = d;
        exp_stat  = s;
        exp_ready = 1'b1;
        exp_dv++;
        exp_sv++;
        chk({tag, ".latency"}, t_sv - t_rise, 3);
        check_state(tag);
    endtask

    initial begin
        logic [15:0] d;
        logic [87:0] s;
        exp_dv = 0; exp_sv = 0; exp_err = 0;
        model_reset();

        tick(4);
        check_state("reset");
        RST_N = 1'b1;
        tick(4);

        // Stall after 9 dynamic bits.
        d = 16'($urandom);
        for (int i = 15; i >= 7; i--) send_bit(1'b1, d[i], 9, 8);
        tick(1100);
        exp_err++;
        chk("stall.when", t_err - t_rise, 1027);
        check_state("stall");

        // Short static frame: SEL returns high after 40 static bits.
        d = 16'($urandom);
        send_dyn(d, 9, 8);
        for (int i = 0; i < 40; i++) send_bit(1'b0, 1'($urandom), 9, 8);
        send_bit(1'b1, 1'b0, 9, 8);
        tick(6);
        exp_dyn = d;
        exp_dv++;
        exp_err++;
        check_state("short");

        // Nominal frame at a 17:1 ratio.
        send_frame("nominal", 16'hABC6, 88'h123456789ABCDEF1234567, 9, 8);

        // Second frame after SEL drops in DONE.
        SEL_IN = 1'b0;
        tick(5);
        send_frame("second", 16'h5A5A, 88'hFFFFFFFFFF000000000000, 9, 8);

        // Reset during static bit 50.
        SEL_IN = 1'b0;
        tick(5);
        send_dyn(16'h1234, 9, 8);
        for (int i = 0; i < 49; i++) send_bit(1'b0, 1'($urandom), 9, 8);
        SEL_IN  = 1'b0;
        MOSI_IN = 1'b1;
        tick(9);
        SCLK_IN = 1'b1;
        tick(2);
        exp_dv++;
        chk("pre_rst.dyn", DYNCNF, 16'h1234);
        #2 RST_N = 1'b0;
        #1;
        model_reset();
        chk("rst.dyn", DYNCNF, exp_dyn);
        chk("rst.stat", STATCNF, exp_stat);
        chk("rst.ready", cfg_ready, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.pulses", {dyn_valid, stat_valid, frame_err}, 3'b000);
        @(negedge CLK);
        SCLK_IN = 1'b0;
        tick(3);
        RST_N = 1'b1;
        tick(3);
        s = {$urandom, $urandom, 24'($urandom)};
        send_frame("post_rst", 16'($urandom), s, 9, 8);

        // Minimum ratio, random data.
        for (int f = 0; f < 20; f++) begin
            SEL_IN = 1'b0;
            tick(3);
            s = {$urandom, $urandom, 24'($urandom)};
            send_frame("rand", 16'($urandom), s, 2, 2);
        end

        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
